// File: rtl/psk_phase_demapper.sv
// Purpose : demaps received 3-bit phase codes to QPSK/8PSK symbols and serializes them MSB-first.
// Latency : symbol accepted at edge k into an empty, idle block shows its MSB on bit_out after edge k+1.
// Backpr. : phase_ready = !full; bit_out/bit_valid hold while bit_ready is low; no bubble between symbols.
//
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   mode                  - 0 = QPSK (2 bits/symbol), 1 = 8PSK (3 bits/symbol), taken per accepted code
//   phase_in/_valid/_ready- received phase code stream (valid/ready)
//   bit_out/_valid/_ready - serial symbol bit stream (valid/ready)
//   sym_err               - one-cycle pulse after an accepted QPSK code with wrong parity
//   err_count             - saturating count of sym_err pulses
module psk_phase_demapper #(
    parameter int FIFO_DEPTH = 4,
    parameter bit DIFF_EN    = 1'b1,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [2:0]       phase_in,
    input  logic             phase_valid,
    output logic             phase_ready,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             sym_err,
    output logic [ERR_W-1:0] err_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    // Odd codes are the valid QPSK points in absolute phase; in differential
    // mode the valid steps are multiples of 90 degrees, i.e. even differences.
    localparam logic PAR_OK = DIFF_EN ? 1'b0 : 1'b1;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    // FIFO entry: {mode, symbol[2:0]}
    logic [3:0]       r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [2:0]       r_prev;
    logic             r_sym_err;
    logic [ERR_W-1:0] r_err_cnt;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_shift;
    logic [1:0]       r_cnt;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic             w_shift_en;
    logic [2:0]       w_diff;
    logic [2:0]       w_sym;
    logic             w_parity_err;
    logic [3:0]       w_head;

    // Extra pointer MSB tells full from empty when the index bits match.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    assign phase_ready  = !rst && !w_full;
    assign w_push       = phase_valid && phase_ready;
    assign w_diff       = DIFF_EN ? 3'(phase_in - r_prev) : phase_in;
    assign w_sym        = mode ? w_diff : {1'b0, w_diff[2:1]};
    assign w_parity_err = !mode && (w_diff[0] != PAR_OK);
    assign w_head       = r_mem[r_rptr[AW-1:0]];

    assign sym_err   = r_sym_err;
    assign err_count = r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: the pointers decide what is live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= {mode, w_sym};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev    <= '0;
            r_sym_err <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_sym_err <= w_push && w_parity_err;
            if (w_push && w_parity_err && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            if (w_push)
                r_prev <= phase_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs. On the last bit of a symbol the next
    // FIFO head is loaded in the same edge so back-to-back symbols have no gap.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_shift_en  = 1'b0;
        bit_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bit_valid = 1'b1;
                if (bit_ready) begin
                    if (r_cnt == 2'd1) begin
                        if (!w_empty) begin
                            w_pop  = 1'b1;
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_shift_en = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        bit_out = bit_valid && r_shift[2];
    end

    // Symbols are left-aligned so the current MSB is always r_shift[2].
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_shift <= w_head[3] ? w_head[2:0] : {w_head[1:0], 1'b0};
            r_cnt   <= w_head[3] ? 2'd3 : 2'd2;
        end else if (w_shift_en) begin
            r_shift <= {r_shift[1:0], 1'b0};
            r_cnt   <= r_cnt - 2'd1;
        end
    end
endmodule

// File: tb/tb_psk_phase_demapper.sv
module tb_psk_phase_demapper;
    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [2:0] phase_in;
    logic       phase_valid;
    logic       bit_ready;

    // u0: absolute phase, ERR_W=8; u1: differential, ERR_W=2
    logic       phase_ready0, bit_out0, bit_valid0, sym_err0;
    logic [7:0] err_count0;
    logic       phase_ready1, bit_out1, bit_valid1, sym_err1;
    logic [1:0] err_count1;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    bit q0[$];
    bit q1[$];
    logic [2:0] prev1 = 3'd0;
    logic exp_serr0 = 1'b0;
    logic exp_serr1 = 1'b0;
    int   exp_cnt0 = 0;
    int   exp_cnt1 = 0;
    int   hs0 = 0;
    int   hs1 = 0;

    always #5 clk = ~clk;

    psk_phase_demapper #(.FIFO_DEPTH(4), .DIFF_EN(1'b0), .ERR_W(8)) u0 (
        .clk(clk), .rst(rst), .mode(mode), .phase_in(phase_in),
        .phase_valid(phase_valid), .phase_ready(phase_ready0),
        .bit_out(bit_out0), .bit_valid(bit_valid0), .bit_ready(bit_ready),
        .sym_err(sym_err0), .err_count(err_count0));

    psk_phase_demapper #(.FIFO_DEPTH(4), .DIFF_EN(1'b1), .ERR_W(2)) u1 (
        .clk(clk), .rst(rst), .mode(mode), .phase_in(phase_in),
        .phase_valid(phase_valid), .phase_ready(phase_ready1),
        .bit_out(bit_out1), .bit_valid(bit_valid1), .bit_ready(bit_ready),
        .sym_err(sym_err1), .err_count(err_count1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard: expectations pushed when a code is about to be accepted,
    // popped on every bit handshake. Inputs only change #1 after posedge.
    always @(negedge clk) begin
        logic [2:0] d0;
        logic [2:0] d1;
        bit b;
        if (mon_en) begin
            check("sym_err0", sym_err0, exp_serr0);
            check("sym_err1", sym_err1, exp_serr1);
            check("err_count0", err_count0, exp_cnt0);
            check("err_count1", err_count1, exp_cnt1);
            if (!rst) begin
                if (q0.size() == 0) check("stale_bit0", bit_valid0, 1'b0);
                else if (bit_valid0 && bit_ready) begin
                    b = q0.pop_front();
                    check("bit0", bit_out0, b);
                    hs0++;
                end
                if (q1.size() == 0) check("stale_bit1", bit_valid1, 1'b0);
                else if (bit_valid1 && bit_ready) begin
                    b = q1.pop_front();
                    check("bit1", bit_out1, b);
                    hs1++;
                end
            end
        end
        if (rst) begin
            q0.delete();
            q1.delete();
            prev1     = 3'd0;
            exp_serr0 = 1'b0;
            exp_serr1 = 1'b0;
            exp_cnt0  = 0;
            exp_cnt1  = 0;
        end else begin
            exp_serr0 = 1'b0;
            exp_serr1 = 1'b0;
            if (phase_valid && phase_ready0) begin
                d0 = phase_in;
                q0.push_back(d0[2]);
                q0.push_back(d0[1]);
                if (mode) q0.push_back(d0[0]);
                if (!mode && d0[0] != 1'b1) begin
                    exp_serr0 = 1'b1;
                    if (exp_cnt0 < 255) exp_cnt0++;
                end
            end
            if (phase_valid && phase_ready1) begin
                d1 = phase_in - prev1;
                prev1 = phase_in;
                q1.push_back(d1[2]);
                q1.push_back(d1[1]);
                if (mode) q1.push_back(d1[0]);
                if (!mode && d1[0] != 1'b0) begin
                    exp_serr1 = 1'b1;
                    if (exp_cnt1 < 3) exp_cnt1++;
                end
            end
        end
    end

    // Holds the code until accepted; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [2:0] p, input logic m);
        logic acc;
        acc = 1'b0;
        phase_in    = p;
        mode        = m;
        phase_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            acc = phase_ready0;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        check("send_accepted", acc, 1'b1);
        phase_valid = 1'b0;
    endtask

    task automatic drain();
        bit_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (q0.size() == 0 && q1.size() == 0 && !bit_valid0 && !bit_valid1) break;
        end
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check("ready_in_rst", phase_ready0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int base0;
        int base1;
        rst = 1'b1; mode = 1'b0; phase_in = 3'd0; phase_valid = 1'b0; bit_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bit_valid0", bit_valid0, 1'b0);
        check("rst_bit_valid1", bit_valid1, 1'b0);
        check("rst_bit_out0", bit_out0, 1'b0);
        check("rst_sym_err0", sym_err0, 1'b0);
        check("rst_err_count0", err_count0, 8'd0);
        check("rst_err_count1", err_count1, 2'd0);
        check("rst_phase_ready0", phase_ready0, 1'b0);
        check("rst_phase_ready1", phase_ready1, 1'b0);
        mon_en = 1'b1;
        rst = 1'b0;
        #1;
        check("ready_after_rst", phase_ready0, 1'b1);

        // 8PSK 5,2 back-to-back: first bit one edge after first accept, 6 bits no gap
        send(3'd5, 1'b1);
        check("lat_not_yet", bit_valid0, 1'b0);
        send(3'd2, 1'b1);
        check("lat_first_valid", bit_valid0, 1'b1);
        check("lat_first_msb", bit_out0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("no_bubble", bit_valid0, 1'b1);
        end
        @(posedge clk);
        #1;
        check("idle_after_6", bit_valid0, 1'b0);
        drain();

        // QPSK 1,3,3,7 from prev=0: differential d=1(err),2,0,4
        pulse_reset();
        send(3'd1, 1'b0);
        check("serr1_first", sym_err1, 1'b1);
        check("serr0_first", sym_err0, 1'b0);
        send(3'd3, 1'b0);
        send(3'd3, 1'b0);
        send(3'd7, 1'b0);
        drain();
        check("qpsk_err_count1", err_count1, 2'd1);
        check("qpsk_err_count0", err_count0, 8'd0);

        // Backpressure: 1 in shifter + 4 in FIFO, then stall
        bit_ready = 1'b0;
        base0 = hs0;
        base1 = hs1;
        for (int p = 1; p <= 5; p++) send(3'(p), 1'b1);
        check("full_ready0", phase_ready0, 1'b0);
        check("full_ready1", phase_ready1, 1'b0);
        phase_in = 3'd6; mode = 1'b1; phase_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall_ready", phase_ready0, 1'b0);
            check("hold_valid", bit_valid0, 1'b1);
            check("hold_bit", bit_out0, 1'b0);
        end
        phase_valid = 1'b0;
        drain();
        check("bp_bits0", hs0 - base0, 15);
        check("bp_bits1", hs1 - base1, 15);

        // Wrap-around: 7 then 1 -> differential 7, 2
        pulse_reset();
        base1 = hs1;
        send(3'd7, 1'b1);
        send(3'd1, 1'b1);
        drain();
        check("wrap_bits1", hs1 - base1, 6);

        // Reset mid-SHIFT with 1 of 3 bits sent and 2 entries queued
        pulse_reset();
        send(3'd0, 1'b0);
        send(3'd1, 1'b0);
        drain();
        check("pre_rst_cnt0", err_count0, 8'd1);
        check("pre_rst_cnt1", err_count1, 2'd1);
        send(3'd3, 1'b1);
        send(3'd4, 1'b1);
        send(3'd6, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_valid0", bit_valid0, 1'b0);
        check("mid_rst_valid1", bit_valid1, 1'b0);
        check("mid_rst_cnt0", err_count0, 8'd0);
        check("mid_rst_cnt1", err_count1, 2'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("no_stale", bit_valid0, 1'b0);
        end
        send(3'd3, 1'b1);
        drain();

        // Saturation on the 2-bit counter: five odd differences
        pulse_reset();
        for (int p = 1; p <= 5; p++) send(3'(p), 1'b0);
        drain();
        check("sat_cnt1", err_count1, 2'd3);
        check("sat_cnt0", err_count0, 8'd2);

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
